// File: rtl/clkdiv_pkg.sv
// Shared helpers for the integer clock divider: counter width and low-phase length.
package clkdiv_pkg;

  function automatic int clkdiv_cnt_w(input int divisor);
    return (divisor <= 1) ? 1 : $clog2(divisor);
  endfunction

  // Odd divisors put the extra cycle in the low phase.
  function automatic int clkdiv_low_cyc(input int divisor);
    return (divisor + 1) / 2;
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Mod-DIVISOR up-counter with asynchronous active-low reset; exposes the current
// count and the combinational next count so the caller can register decisions on it.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int DIVISOR = 25,
  parameter int CNT_W   = clkdiv_cnt_w(DIVISOR)
) (
  input  logic             clk_in,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_MAX) cnt_d = '0;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider producing a registered clk_out of period DIVISOR clk_in cycles.
// Optional CLKDIV_TICK_EN adds a one-cycle tick marking each clk_out rising phase.
module clock_divider
  import clkdiv_pkg::*;
#(
  parameter int DIVISOR = 25
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic tick
`endif
);

  generate
    if (DIVISOR < 1) begin : g_bad_divisor
      $error("clock_divider: DIVISOR must be >= 1");
    end else if (DIVISOR == 1) begin : g_bypass
      // No division possible: pass the clock through, gated low while in reset.
      assign clk_out = clk_in & reset;
`ifdef CLKDIV_TICK_EN
      assign tick = reset;
`endif
    end else begin : g_div
      localparam int CNT_W   = clkdiv_cnt_w(DIVISOR);
      localparam int LOW_CYC = clkdiv_low_cyc(DIVISOR);

      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             clk_out_q;
      logic             clk_out_d;

      clkdiv_counter #(
        .DIVISOR (DIVISOR),
        .CNT_W   (CNT_W)
      ) u_counter (
        .clk_in    (clk_in),
        .reset     (reset),
        .cnt_o     (cnt),
        .cnt_nxt_o (cnt_nxt)
      );

      // Deciding on the next count keeps clk_out aligned with the counter register.
      assign clk_out_d = (cnt_nxt >= CNT_W'(LOW_CYC));

      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) clk_out_q <= 1'b0;
        else        clk_out_q <= clk_out_d;
      end

      assign clk_out = clk_out_q;

`ifdef CLKDIV_TICK_EN
      logic tick_q;
      logic tick_d;

      assign tick_d = (cnt_nxt == CNT_W'(LOW_CYC));

      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) tick_q <= 1'b0;
        else        tick_q <= tick_d;
      end

      assign tick = tick_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider at DIVISOR 1, 2, 3, 4, 8 and 25 (tick checked when CLKDIV_TICK_EN is set).
module tb_clock_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d1, rst_d2, rst_d3, rst_d4, rst_d8, rst_d25;
  logic co_d1, co_d2, co_d3, co_d4, co_d8, co_d25;
`ifdef CLKDIV_TICK_EN
  logic tk_d1, tk_d2, tk_d3, tk_d4, tk_d8, tk_d25;
`endif

  clock_divider #(.DIVISOR(1)) u_d1 (.clk_in(clk), .reset(rst_d1), .clk_out(co_d1)
`ifdef CLKDIV_TICK_EN
    , .tick(tk_d1)
`endif
  );
  clock_divider #(.DIVISOR(2)) u_d2 (.clk_in(clk), .reset(rst_d2), .clk_out(co_d2)
`ifdef CLKDIV_TICK_EN
    , .tick(tk_d2)
`endif
  );
  clock_divider #(.DIVISOR(3)) u_d3 (.clk_in(clk), .reset(rst_d3), .clk_out(co_d3)
`ifdef CLKDIV_TICK_EN
    , .tick(tk_d3)
`endif
  );
  clock_divider #(.DIVISOR(4)) u_d4 (.clk_in(clk), .reset(rst_d4), .clk_out(co_d4)
`ifdef CLKDIV_TICK_EN
    , .tick(tk_d4)
`endif
  );
  clock_divider #(.DIVISOR(8)) u_d8 (.clk_in(clk), .reset(rst_d8), .clk_out(co_d8)
`ifdef CLKDIV_TICK_EN
    , .tick(tk_d8)
`endif
  );
  clock_divider #(.DIVISOR(25)) u_d25 (.clk_in(clk), .reset(rst_d25), .clk_out(co_d25)
`ifdef CLKDIV_TICK_EN
    , .tick(tk_d25)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected clk_out after edge k (index k) following reset release.
  logic [1:24] pat_d2  = 24'b101010101010101010101010;
  logic [1:24] pat_d3  = 24'b010010010010010010010010;
  logic [1:24] pat_d4  = 24'b011001100110011001100110;
  logic [1:24] pat_tk4 = 24'b010001000100010001000100;
  logic [1:8]  pat_d8  = 8'b00011110;

  int   rises25;
  int   last_rise25;
  int   last_fall25;
  logic prev25;

  initial begin
    rst_d1 = 1'b0; rst_d2 = 1'b0; rst_d3 = 1'b0;
    rst_d4 = 1'b0; rst_d8 = 1'b0; rst_d25 = 1'b0;
    rises25 = 0; last_rise25 = 0; last_fall25 = 0; prev25 = 1'b0;

    #2;
    check("rst_d2", co_d2, 1'b0);
    check("rst_d3", co_d3, 1'b0);
    check("rst_d25", co_d25, 1'b0);
    #5;
    check("rst_d1_clkhigh", co_d1, 1'b0);
    check("rst_d4_after_edge", co_d4, 1'b0);
    check("rst_d8_after_edge", co_d8, 1'b0);
`ifdef CLKDIV_TICK_EN
    check("rst_tick_d4", tk_d4, 1'b0);
    check("rst_tick_d1", tk_d1, 1'b0);
`endif

    @(negedge clk);
    rst_d1 = 1'b1; rst_d2 = 1'b1; rst_d3 = 1'b1;
    rst_d4 = 1'b1; rst_d8 = 1'b1; rst_d25 = 1'b1;

    for (int k = 1; k <= 270; k++) begin
      @(posedge clk);
      #1;
      if (k <= 24) begin
        check($sformatf("d2_edge%0d", k), co_d2, pat_d2[k]);
        check($sformatf("d3_edge%0d", k), co_d3, pat_d3[k]);
        check($sformatf("d4_edge%0d", k), co_d4, pat_d4[k]);
        check($sformatf("d1_high_edge%0d", k), co_d1, 1'b1);
`ifdef CLKDIV_TICK_EN
        check($sformatf("tick_d4_edge%0d", k), tk_d4, pat_tk4[k]);
        check($sformatf("tick_d1_edge%0d", k), tk_d1, 1'b1);
`endif
      end
      if (k <= 8) check($sformatf("d8_edge%0d", k), co_d8, pat_d8[k]);
      if (co_d25 && !prev25) begin
        rises25++;
        if (rises25 == 1) begin
          check_int("d25_first_rise_edge", k, 13);
        end else begin
          check_int($sformatf("d25_period_%0d", rises25), k - last_rise25, 25);
          check_int($sformatf("d25_low_len_%0d", rises25), k - last_fall25, 13);
        end
        last_rise25 = k;
      end
      if (!co_d25 && prev25) begin
        check_int($sformatf("d25_high_len_%0d", rises25), k - last_rise25, 12);
        last_fall25 = k;
      end
      prev25 = co_d25;
    end
    check_int("d25_rise_count", rises25, 11);

    @(negedge clk);
    #1;
    check("d1_low_phase", co_d1, 1'b0);
    // Edge 270 leaves the DIVISOR=8 counter at 6, inside its high phase.
    check("d8_high_before_reset", co_d8, 1'b1);
    rst_d8 = 1'b0;
    #1;
    check("d8_async_reset", co_d8, 1'b0);

    rst_d1 = 1'b0;
    @(posedge clk);
    #1;
    check("d1_forced_low", co_d1, 1'b0);
    check("d8_held_in_reset", co_d8, 1'b0);
    @(posedge clk);
    #1;
    check("d8_held_in_reset2", co_d8, 1'b0);

    @(negedge clk);
    rst_d8 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("d8_restart_edge%0d", k), co_d8, pat_d8[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
